d_sram_axi_bridge: RTL
======================

// Module: d_sram_axi_bridge
// PURPOSE
//  Downstream neighbour of the data cache. Converts the cache's SRAM-like miss/writeback port
//  (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata) into single-beat AXI3/AXI-lite transactions.
//  One transaction outstanding at a time. Sits between the D-cache and the SoC AXI crossbar.
// PARAMETERS
//  ID_W    4  width of AXI id fields
//  RD_ID   0  arid value for reads
//  WR_ID   1  awid/wid value for writes
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset
//  data_req       in   1     request from cache, held until data_addr_ok
//  data_wr        in   1     1=write, 0=read
//  data_size      in   2     0=byte, 1=half, 2=word
//  data_addr      in   32    byte address
//  data_wdata     in   32    write data, lane-aligned
//  data_rdata     out  32    read data, valid with data_data_ok
//  data_addr_ok   out  1     request accepted this cycle
//  data_data_ok   out  1     transaction complete this cycle
//  arid/araddr/arsize/arvalid  out  ID_W/32/3/1   read address channel
//  arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3   fixed 0/01/0/0/0
//  arready        in   1
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1   read data channel
//  rready         out  1
//  awid/awaddr/awsize/awvalid  out  ID_W/32/3/1   write address channel
//  awlen/awburst/awlock/awcache/awprot  out  8/2/2/4/3   fixed 0/01/0/0/0
//  awready        in   1
//  wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1   write data channel, wlast=1
//  wready         in   1
//  bid/bresp/bvalid  in  ID_W/2/1   write response channel
//  bready         out  1
// BEHAVIOUR
//  - Reset: clk, rst asynchronous active-high. All valid/ready outputs 0, data_addr_ok=0,
//    data_data_ok=0, state IDLE, latched addr/size/wdata = 0. Reset mid-transaction abandons it.
//  - FSM: IDLE -> RD_A -> RD_D -> IDLE; IDLE -> WR_AW -> WR_B -> IDLE.
//  - IDLE: data_addr_ok = data_req (combinational). On accept latch addr, size, wdata, wr;
//    go RD_A if wr=0, else WR_AW. Requests are not accepted in any other state.
//  - RD_A: arvalid=1, araddr/arsize={1'b0,size} from latch; on arvalid&arready -> RD_D.
//  - RD_D: rready=1; on rvalid: data_data_ok=1, data_rdata=rdata (pass-through), -> IDLE.
//  - WR_AW: awvalid and wvalid both raised on entry; each drops independently after its own
//    handshake (aw_done/w_done flags). When both done (including same cycle) -> WR_B.
//  - WR_B: bready=1; on bvalid: data_data_ok=1, -> IDLE.
//  - wstrb: size0 -> 4'b0001<<addr[1:0]; size1 -> addr[1]?1100:0011; size2 -> 1111.
//  - Latency with zero-wait slave: accept T, arvalid T+1, data_ok at T+2 earliest;
//    next request accepted at T+3 earliest (data_ok cycle is not IDLE).
//  - rid/bid/rlast ignored (single outstanding). rresp/bresp ignored unless feature below.
//  - Valid outputs never drop before handshake; addr/data stable while valid.
// CONFIGURATION
//  BRIDGE_BUS_ERR_EN defined: extra output bus_err (1 bit), sticky, set when rresp!=0 at
//    R handshake or bresp!=0 at B handshake; cleared only by rst. data path unchanged.
//  Not defined: no bus_err port, resp fields unused.
// TESTING
//  - Read, zero-wait: req addr 0x1FC0_0010 size2 -> araddr 0x1FC0_0010 arsize 2, rdata
//    0xDEADBEEF returned with data_data_ok 2 cycles after accept.
//  - Byte write addr 0x...03 wdata 0xAB000000 -> wstrb 1000, wlast 1, data_ok only on bvalid.
//  - Write with awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle,
//    awvalid held 3 cycles, exactly one AW and one W handshake.
//  - arready stalled 5 cycles, data_req held -> no second addr_ok, araddr stable throughout.
//  - Reset asserted in RD_D -> all valids/readies 0 next edge, state IDLE, no data_ok.
//  - With BRIDGE_BUS_ERR_EN: bresp=2'b10 -> bus_err=1, remains 1 after later OKAY reads.

Source files
------------

// File: rtl/d_sram_axi_bridge_if.sv
// Bundle of the D-cache SRAM-like port and the single-beat AXI3 port seen by d_sram_axi_bridge.
// master = bridge side; slave = cache + AXI interconnect side.
interface d_sram_axi_bridge_if #(
    parameter int unsigned ID_W = 4
);
    logic            data_req;
    logic            data_wr;
    logic [1:0]      data_size;
    logic [31:0]     data_addr;
    logic [31:0]     data_wdata;
    logic [31:0]     data_rdata;
    logic            data_addr_ok;
    logic            data_data_ok;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [2:0]      arsize;
    logic            arvalid;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [2:0]      awsize;
    logic            awvalid;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arsize, arvalid, arlen, arburst, arlock, arcache, arprot,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awsize, awvalid, awlen, awburst, awlock, awcache, awprot,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arsize, arvalid, arlen, arburst, arlock, arcache, arprot,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awsize, awvalid, awlen, awburst, awlock, awcache, awprot,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/d_sram_axi_bridge.sv
// D-cache SRAM-like port to single-beat AXI3 bridge, one transaction outstanding.
// Optional BRIDGE_BUS_ERR_EN adds a sticky bus_err_o flag for non-OKAY R/B responses.
module d_sram_axi_bridge #(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned RD_ID = 0,
    parameter int unsigned WR_ID = 1
) (
    input  logic clk,
    input  logic rst,
    d_sram_axi_bridge_if.master bus_io
`ifdef BRIDGE_BUS_ERR_EN
    ,
    output logic bus_err_o
`endif
);

    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [3:0]  wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.data_req) begin
                    addr_d    = bus_io.data_addr;
                    size_d    = bus_io.data_size;
                    wdata_d   = bus_io.data_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus_io.data_wr ? StWrAw : StRdA;
                end
            end
            StRdA: if (bus_io.arready) state_d = StRdD;
            StRdD: if (bus_io.rvalid) state_d = StIdle;
            StWrAw: begin
                // AW and W complete independently; leave once both have handshaken.
                aw_done_d = aw_done_q | bus_io.awready;
                w_done_d  = w_done_q | bus_io.wready;
                if (aw_done_d && w_done_d) state_d = StWrB;
            end
            StWrB: if (bus_io.bvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign bus_io.data_addr_ok = (state_q == StIdle) && bus_io.data_req;
    assign bus_io.data_data_ok = ((state_q == StRdD) && bus_io.rvalid) ||
                                 ((state_q == StWrB) && bus_io.bvalid);
    assign bus_io.data_rdata   = bus_io.rdata;

    assign bus_io.arid    = ID_W'(RD_ID);
    assign bus_io.araddr  = addr_q;
    assign bus_io.arsize  = {1'b0, size_q};
    assign bus_io.arvalid = (state_q == StRdA);
    assign bus_io.arlen   = 8'd0;
    assign bus_io.arburst = 2'b01;
    assign bus_io.arlock  = 2'b00;
    assign bus_io.arcache = 4'd0;
    assign bus_io.arprot  = 3'd0;
    assign bus_io.rready  = (state_q == StRdD);

    assign bus_io.awid    = ID_W'(WR_ID);
    assign bus_io.awaddr  = addr_q;
    assign bus_io.awsize  = {1'b0, size_q};
    assign bus_io.awvalid = (state_q == StWrAw) && !aw_done_q;
    assign bus_io.awlen   = 8'd0;
    assign bus_io.awburst = 2'b01;
    assign bus_io.awlock  = 2'b00;
    assign bus_io.awcache = 4'd0;
    assign bus_io.awprot  = 3'd0;

    assign bus_io.wid     = ID_W'(WR_ID);
    assign bus_io.wdata   = wdata_q;
    assign bus_io.wstrb   = wstrb;
    assign bus_io.wlast   = 1'b1;
    assign bus_io.wvalid  = (state_q == StWrAw) && !w_done_q;
    assign bus_io.bready  = (state_q == StWrB);

    // IDs and rlast carry no information with a single transaction in flight.
    logic unused_resp;
    assign unused_resp = ^{bus_io.rid, bus_io.rlast, bus_io.bid, bus_io.rresp, bus_io.bresp};

`ifdef BRIDGE_BUS_ERR_EN
    logic bus_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (((state_q == StRdD) && bus_io.rvalid && (bus_io.rresp != 2'b00)) ||
                     ((state_q == StWrB) && bus_io.bvalid && (bus_io.bresp != 2'b00))) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err_o = bus_err_q;
`endif

endmodule
